// File: rtl/store_buffer_if.sv
// Core/cache-facing signal bundle for the store buffer.
// The master modport drives requests; the slave modport is the buffer itself.
interface store_buffer_if;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        cache_miss;
    logic        cache_wr_req;
    logic [31:0] cache_addr;
    logic [31:0] cache_wr_data;
    logic [3:0]  cache_be;
    logic        st_stall;
    logic        ld_stall;
    logic        empty;
    logic        full;

    modport master (
        output st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, cache_miss,
        input  cache_wr_req, cache_addr, cache_wr_data, cache_be,
        input  st_stall, ld_stall, empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_be, ld_valid, ld_addr, cache_miss,
        output cache_wr_req, cache_addr, cache_wr_data, cache_be,
        output st_stall, ld_stall, empty, full
    );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and the data cache. Stores drain one per
// cycle when no load is pending; loads to a buffered word stall (no forwarding).
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input logic          clk_i,
    input logic          rst_ni,
    store_buffer_if.slave bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;

    logic [29:0]       addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        be_q   [DEPTH];

    logic full, empty, push, pop, conflict, draining;

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    // A full buffer never admits a store, even if the head pops this same cycle.
    assign push     = bus.st_valid & ~full;
    assign draining = (state_q == StDrain);
    assign pop      = draining & ~bus.cache_miss;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (push) begin
            wr_ptr_d          = wr_ptr_q + PtrW'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (pop) begin
            rd_ptr_d          = rd_ptr_q + PtrW'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Counting the same-cycle push lets a store reach the cache one cycle after enqueue.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if ((!empty || push) && !bus.ld_valid) state_d = StDrain;
            end
            StDrain: begin
                if (pop) state_d = (count_d != '0 && !bus.ld_valid) ? StDrain : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        conflict = push && (bus.st_addr[31:2] == bus.ld_addr[31:2]);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == bus.ld_addr[31:2])) conflict = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Payload needs no reset; validity is tracked separately.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.st_addr[31:2];
            data_q[wr_ptr_q] <= bus.st_data;
            be_q[wr_ptr_q]   <= bus.st_be;
        end
    end

    always_comb begin
        bus.cache_wr_req  = draining;
        bus.cache_addr    = '0;
        bus.cache_wr_data = '0;
        bus.cache_be      = '0;
        if (draining) begin
            bus.cache_addr    = {addr_q[rd_ptr_q], 2'b00};
            bus.cache_wr_data = data_q[rd_ptr_q];
            bus.cache_be      = be_q[rd_ptr_q];
        end
    end

    assign bus.st_stall = bus.st_valid & full;
    assign bus.ld_stall = bus.ld_valid & (draining | conflict);
    assign bus.empty    = empty;
    assign bus.full     = full;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH = 4).
module tb_store_buffer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    store_buffer_if bus ();

    store_buffer #(.DEPTH(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.st_valid   = 1'b0;
        bus.st_addr    = '0;
        bus.st_data    = '0;
        bus.st_be      = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_addr    = '0;
        bus.cache_miss = 1'b0;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_be    = be;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        #12;
        for (int pass = 0; pass < 2; pass++) begin
            checks++;
            if (bus.cache_wr_req !== 1'b0) begin
                failures++; $display("FAIL reset_req[%0d] got=%b exp=0", pass, bus.cache_wr_req);
            end
            checks++;
            if (bus.empty !== 1'b1) begin
                failures++; $display("FAIL reset_empty[%0d] got=%b exp=1", pass, bus.empty);
            end
            checks++;
            if (bus.full !== 1'b0) begin
                failures++; $display("FAIL reset_full[%0d] got=%b exp=0", pass, bus.full);
            end
            checks++;
            if (bus.st_stall !== 1'b0 || bus.ld_stall !== 1'b0) begin
                failures++;
                $display("FAIL reset_stalls[%0d] got st=%b ld=%b exp=0/0", pass, bus.st_stall,
                         bus.ld_stall);
            end
            if (pass == 0) begin
                tick();
                rst_n = 1'b1;
                #1;
            end
        end
    endtask

    task automatic test_single;
        tick();
        set_store(32'h104, 32'hAABB_CCDD, 4'hF);
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.cache_wr_req !== 1'b0) begin
            failures++;
            $display("FAIL single_pre got empty=%b req=%b exp 1/0", bus.empty, bus.cache_wr_req);
        end
        tick();
        bus.st_valid = 1'b0;
        #1;
        checks++;
        if (bus.cache_wr_req !== 1'b1) begin
            failures++; $display("FAIL single_req got=%b exp=1", bus.cache_wr_req);
        end
        checks++;
        if (bus.cache_addr !== 32'h104) begin
            failures++; $display("FAIL single_addr got=%h exp=00000104", bus.cache_addr);
        end
        checks++;
        if (bus.cache_wr_data !== 32'hAABB_CCDD || bus.cache_be !== 4'hF) begin
            failures++;
            $display("FAIL single_data got=%h/%h exp=aabbccdd/f", bus.cache_wr_data, bus.cache_be);
        end
        tick();
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.cache_wr_req !== 1'b0 || bus.cache_addr !== 32'h0) begin
            failures++;
            $display("FAIL single_post got empty=%b req=%b addr=%h exp 1/0/0", bus.empty,
                     bus.cache_wr_req, bus.cache_addr);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d [3];
        d[0] = 32'h1111_0001;
        d[1] = 32'h1111_0002;
        d[2] = 32'h1111_0003;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 3) set_store(32'h600 + 32'(4 * k), d[k], 4'hF);
            else bus.st_valid = 1'b0;
            #1;
            if (k >= 1) begin
                checks++;
                if (bus.cache_wr_req !== 1'b1 || bus.cache_wr_data !== d[k-1]) begin
                    failures++;
                    $display("FAIL b2b_drain[%0d] got req=%b data=%h exp 1/%h", k,
                             bus.cache_wr_req, bus.cache_wr_data, d[k-1]);
                end
            end
            if (k == 2) begin
                checks++;
                if (bus.empty !== 1'b0 || bus.full !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_count got empty=%b full=%b exp 0/0", bus.empty, bus.full);
                end
            end
        end
        tick();
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.cache_wr_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got empty=%b req=%b exp 1/0", bus.empty, bus.cache_wr_req);
        end
    endtask

    task automatic test_fill;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h1000;
        for (int k = 0; k < 4; k++) begin
            tick();
            set_store(32'h10 + 32'(4 * k), 32'(8'h11 * (k + 1)), 4'hF);
            #1;
            checks++;
            if (bus.st_stall !== 1'b0) begin
                failures++; $display("FAIL fill_accept[%0d] got st_stall=%b exp=0", k, bus.st_stall);
            end
        end
        tick();
        set_store(32'h20, 32'h55, 4'hF);
        #1;
        checks++;
        if (bus.full !== 1'b1 || bus.st_stall !== 1'b1) begin
            failures++;
            $display("FAIL fill_full got full=%b st_stall=%b exp 1/1", bus.full, bus.st_stall);
        end
        checks++;
        if (bus.cache_wr_req !== 1'b0 || bus.ld_stall !== 1'b0) begin
            failures++;
            $display("FAIL fill_hold got req=%b ld_stall=%b exp 0/0", bus.cache_wr_req,
                     bus.ld_stall);
        end
        tick();
        bus.st_valid = 1'b0;
        #1;
        checks++;
        if (bus.full !== 1'b1 || bus.cache_wr_req !== 1'b0) begin
            failures++;
            $display("FAIL fill_held got full=%b req=%b exp 1/0", bus.full, bus.cache_wr_req);
        end
        tick();
        bus.ld_valid = 1'b0;
        #1;
        checks++;
        if (bus.cache_wr_req !== 1'b0) begin
            failures++; $display("FAIL fill_release got req=%b exp=0", bus.cache_wr_req);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            checks++;
            if (bus.cache_wr_req !== 1'b1 || bus.cache_wr_data !== 32'(8'h11 * (k + 1))) begin
                failures++;
                $display("FAIL fill_drain[%0d] got req=%b data=%h exp 1/%h", k, bus.cache_wr_req,
                         bus.cache_wr_data, 32'(8'h11 * (k + 1)));
            end
        end
        tick();
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.cache_wr_req !== 1'b0) begin
            failures++;
            $display("FAIL fill_no5th got empty=%b req=%b exp 1/0", bus.empty, bus.cache_wr_req);
        end
    endtask

    task automatic test_miss;
        tick();
        bus.cache_miss = 1'b1;
        set_store(32'h200, 32'hDEAD_BEEF, 4'h3);
        #1;
        checks++;
        if (bus.cache_wr_req !== 1'b0) begin
            failures++; $display("FAIL miss_pre got req=%b exp=0", bus.cache_wr_req);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            bus.st_valid = 1'b0;
            #1;
            checks++;
            if (bus.cache_wr_req !== 1'b1 || bus.cache_addr !== 32'h200 ||
                bus.cache_wr_data !== 32'hDEAD_BEEF || bus.cache_be !== 4'h3) begin
                failures++;
                $display("FAIL miss_hold[%0d] got req=%b addr=%h data=%h be=%h exp 1/200/deadbeef/3",
                         k, bus.cache_wr_req, bus.cache_addr, bus.cache_wr_data, bus.cache_be);
            end
        end
        tick();
        bus.cache_miss = 1'b0;
        #1;
        checks++;
        if (bus.cache_wr_req !== 1'b1 || bus.empty !== 1'b0) begin
            failures++;
            $display("FAIL miss_last got req=%b empty=%b exp 1/0", bus.cache_wr_req, bus.empty);
        end
        tick();
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.cache_wr_req !== 1'b0) begin
            failures++;
            $display("FAIL miss_pop got empty=%b req=%b exp 1/0", bus.empty, bus.cache_wr_req);
        end
    endtask

    task automatic test_conflict;
        tick();
        set_store(32'h300, 32'h3333, 4'hF);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h302;
        #1;
        checks++;
        if (bus.ld_stall !== 1'b1) begin
            failures++; $display("FAIL conf_push got ld_stall=%b exp=1", bus.ld_stall);
        end
        tick();
        bus.st_valid = 1'b0;
        #1;
        checks++;
        if (bus.ld_stall !== 1'b1 || bus.cache_wr_req !== 1'b0) begin
            failures++;
            $display("FAIL conf_held got ld_stall=%b req=%b exp 1/0", bus.ld_stall,
                     bus.cache_wr_req);
        end
        tick();
        bus.ld_addr = 32'h304;
        #1;
        checks++;
        if (bus.ld_stall !== 1'b0 || bus.cache_wr_req !== 1'b0) begin
            failures++;
            $display("FAIL conf_other got ld_stall=%b req=%b exp 0/0", bus.ld_stall,
                     bus.cache_wr_req);
        end
        tick();
        bus.ld_valid = 1'b0;
        #1;
        tick();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h302;
        #1;
        checks++;
        if (bus.cache_wr_req !== 1'b1 || bus.ld_stall !== 1'b1 || bus.cache_addr !== 32'h300) begin
            failures++;
            $display("FAIL conf_drain got req=%b ld_stall=%b addr=%h exp 1/1/300",
                     bus.cache_wr_req, bus.ld_stall, bus.cache_addr);
        end
        tick();
        #1;
        checks++;
        if (bus.ld_stall !== 1'b0 || bus.empty !== 1'b1) begin
            failures++;
            $display("FAIL conf_clear got ld_stall=%b empty=%b exp 0/1", bus.ld_stall, bus.empty);
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_wrap;
        int sent;
        int got;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            tick();
            bus.st_valid = (sent < 10) && (cyc % 3 != 2);
            bus.st_addr  = 32'h400 + 32'(4 * sent);
            bus.st_data  = 32'(sent + 1);
            bus.st_be    = 4'hF;
            bus.ld_valid = (cyc % 5 == 1);
            bus.ld_addr  = 32'h2000;
            #1;
            if (bus.cache_wr_req === 1'b1) begin
                checks++;
                if (bus.cache_wr_data !== 32'(got + 1) ||
                    bus.cache_addr !== 32'h400 + 32'(4 * got)) begin
                    failures++;
                    $display("FAIL wrap_order[%0d] got data=%h addr=%h exp %h/%h", got,
                             bus.cache_wr_data, bus.cache_addr, 32'(got + 1),
                             32'h400 + 32'(4 * got));
                end
                got++;
            end
            if (bus.st_valid && !bus.st_stall) sent++;
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (got != 10) begin
            failures++; $display("FAIL wrap_count got=%0d exp=10", got);
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.cache_wr_req !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end got empty=%b req=%b exp 1/0", bus.empty, bus.cache_wr_req);
        end
    endtask

    task automatic test_reset_mid_drain;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h3000;
        for (int k = 0; k < 3; k++) begin
            tick();
            set_store(32'h500 + 32'(4 * k), 32'hA0 + 32'(k), 4'hF);
            #1;
        end
        tick();
        bus.st_valid   = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.cache_miss = 1'b1;
        #1;
        tick();
        checks++;
        if (bus.cache_wr_req !== 1'b1 || bus.cache_wr_data !== 32'hA0) begin
            failures++;
            $display("FAIL rmd_drain got req=%b data=%h exp 1/a0", bus.cache_wr_req,
                     bus.cache_wr_data);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.cache_wr_req !== 1'b0 || bus.full !== 1'b0) begin
            failures++;
            $display("FAIL rmd_async got empty=%b req=%b full=%b exp 1/0/0", bus.empty,
                     bus.cache_wr_req, bus.full);
        end
        tick();
        tick();
        rst_n          = 1'b1;
        bus.cache_miss = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (bus.cache_wr_req !== 1'b0 || bus.empty !== 1'b1) begin
                failures++;
                $display("FAIL rmd_after[%0d] got req=%b empty=%b exp 0/1", k, bus.cache_wr_req,
                         bus.empty);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_miss();
        test_conflict();
        test_wrap();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, meaning the number of store entries (power of two, at least 2).
REQ-002 The block SHALL have one clock and one asynchronous, active-low reset.
REQ-003 Port: clk  in  1  clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: st_valid  in  1  MEM-stage store request.
REQ-006 Port: st_addr  in  32  store byte address.
REQ-007 Port: st_data  in  32  store data, already lane-aligned.
REQ-008 Port: st_be  in  4  byte enables, already shifted by addr[1:0].
REQ-009 Port: ld_valid  in  1  MEM-stage load request to the data cache.
REQ-010 Port: ld_addr  in  32  load byte address.
REQ-011 Port: cache_miss  in  1  data-cache miss/busy indication.
REQ-012 Port: cache_wr_req  out  1  drain write request to the data cache.
REQ-013 Port: cache_addr  out  32  drain address, word-aligned with [1:0] forced to 0.
REQ-014 Port: cache_wr_data  out  32  drain data.
REQ-015 Port: cache_be  out  4  drain byte enables.
REQ-016 Port: st_stall  out  1  store not accepted this cycle.
REQ-017 Port: ld_stall  out  1  load must not issue this cycle.
REQ-018 Port: empty  out  1  buffer holds no entries.
REQ-019 Port: full  out  1  buffer holds DEPTH entries.

Function
REQ-020 Storage SHALL be a circular FIFO with wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH) and count (0..DEPTH).
REQ-021 Each entry SHALL hold addr[31:2], data[31:0] and be[3:0].
REQ-022 The buffer SHALL be written at wr_ptr on a rising edge when st_valid=1 and full=0; wr_ptr and count SHALL then increment.
REQ-023 st_stall SHALL equal st_valid AND full (combinational).
REQ-024 When full, a simultaneous pop SHALL NOT admit a store in the same cycle.
REQ-025 The drain FSM SHALL have states IDLE and DRAIN.
REQ-026 IDLE -> DRAIN SHALL occur when empty=0 and ld_valid=0.
REQ-027 In IDLE with empty=0 and ld_valid=1, the FSM SHALL stay in IDLE, giving loads priority.
REQ-028 In DRAIN, cache_wr_req SHALL be 1, and cache_addr, cache_wr_data and cache_be SHALL present the head entry.
REQ-029 These outputs SHALL be held stable while cache_miss=1.
REQ-030 In a DRAIN cycle with cache_miss=0, the head SHALL pop: rd_ptr increments and count decrements.
REQ-031 After that pop, the FSM SHALL stay in DRAIN if entries remain and ld_valid=0, else return to IDLE.
REQ-032 Minimum latency from enqueue to cache_wr_req SHALL be 1 cycle; sustained drain throughput SHALL be 1 entry per cycle with no misses.
REQ-033 Simultaneous push and pop when not full SHALL leave count unchanged, with both pointers advancing.
REQ-034 ld_stall SHALL equal ld_valid AND (state==DRAIN OR conflict).
REQ-035 conflict SHALL be 1 when any valid entry has addr[31:2]==ld_addr[31:2]; store-to-load forwarding is not performed.
REQ-036 The conflict check SHALL include an entry being pushed in the same cycle.
REQ-037 In IDLE, cache_wr_req SHALL be 0, and cache_addr, cache_wr_data and cache_be SHALL be 0.
REQ-038 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH).

Reset
REQ-039 On rst=0, asynchronously: count=0, wr_ptr=0, rd_ptr=0, FSM=IDLE, all stored entries invalid.
REQ-040 During and after reset: cache_wr_req=0, empty=1, full=0, st_stall=0, ld_stall=0.
REQ-041 Reset asserted mid-DRAIN SHALL discard all pending stores without completing the in-flight write.

Verification
REQ-042 Single store: addr 0x104, data 0xAABBCCDD, be 0xF, cache_miss=0 -> next cycle cache_wr_req=1 with addr 0x104, data 0xAABBCCDD, be 0xF; the cycle after, empty=1.
REQ-043 Fill: 4 back-to-back stores with ld_valid=1 held -> full=1; a 5th store gives st_stall=1 and is not written; cache_wr_req stays 0 until ld_valid drops.
REQ-044 Miss hold: store to 0x200, cache_miss=1 for 5 cycles -> cache_wr_req=1 and outputs stable for 5 cycles; pop in the first cycle with miss=0.
REQ-045 Conflict: buffer holds a store to 0x300; load at 0x302 -> ld_stall=1 until that entry pops; load at 0x304 -> ld_stall=0 while the FSM is in IDLE.
REQ-046 Wrap: 10 stores with data 1..10 interleaved with drains -> cache sees data 1..10 in order; pointers wrap with no loss.
REQ-047 Reset mid-DRAIN with 3 entries -> immediately empty=1 and cache_wr_req=0; no further writes are issued after release.
